// File: rtl/coin_lane_ctrl.sv
// ---------------------------------------------------------------------------
// coin_lane_ctrl
//   Game-side controller for one lane of falling coin sprites. Spawns coins on
//   a fixed frame interval, follows each coin through its flight, judges the
//   player's button presses as hit / miss / whiff, and keeps a saturating
//   score plus a combo count for the score overlay.
//
// Ports
//   i_clk          system clock (only clock)
//   i_rst_n        synchronous reset, active-low
//   i_frame_tick   one-cycle pulse per vsync, already in the i_clk domain
//   i_run          lane enable; low flushes every busy slot
//   i_btn          raw asynchronous player button, active-high
//   i_in_position  per-coin "inside the hit window" status
//   o_active       per-coin active input (high while the coin is falling)
//   o_score        accumulated score, saturating at 16'hFFFF
//   o_combo        consecutive hits, saturating at 255
//   o_hit          one-cycle pulse: a coin was hit
//   o_miss         one-cycle pulse: a coin left the window unhit or timed out
//   o_whiff        one-cycle pulse: press with no coin in the window
//   o_spawn_drop   one-cycle pulse: spawn was due but no slot was free
// ---------------------------------------------------------------------------
module coin_lane_ctrl #(
    parameter int NUM_COINS      = 4,
    parameter int SPAWN_INTERVAL = 12,
    parameter int MAX_FRAMES     = 48,
    parameter int REARM_FRAMES   = 2,
    parameter int HIT_POINTS     = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_tick,
    input  logic                 i_run,
    input  logic                 i_btn,
    input  logic [NUM_COINS-1:0] i_in_position,
    output logic [NUM_COINS-1:0] o_active,
    output logic [15:0]          o_score,
    output logic [7:0]           o_combo,
    output logic                 o_hit,
    output logic                 o_miss,
    output logic                 o_whiff,
    output logic                 o_spawn_drop
);

    // Slot states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLY   = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;
    localparam logic [1:0] ST_REL   = 2'd3;

    // Terminal counts: a counter equal to these on a frame tick completes the interval
    localparam logic [7:0]           SPAWN_LAST = 8'(SPAWN_INTERVAL - 1);
    localparam logic [7:0]           MAX_LAST   = 8'(MAX_FRAMES - 1);
    localparam logic [7:0]           REARM_LAST = 8'(REARM_FRAMES - 1);
    localparam logic [16:0]          HIT_INC    = 17'(HIT_POINTS);
    localparam logic [NUM_COINS-1:0] ONE_N      = NUM_COINS'(1);

    // Isolate the lowest set bit (lowest-index slot wins every arbitration)
    function automatic logic [NUM_COINS-1:0] lowest_one(input logic [NUM_COINS-1:0] v);
        return v & (~v + ONE_N);
    endfunction

    logic                            btn_meta_q, btn_meta_d;
    logic                            btn_sync_q, btn_sync_d;
    logic                            btn_prev_q, btn_prev_d;
    logic [7:0]                      spawn_cnt_q, spawn_cnt_d;
    logic [NUM_COINS-1:0][1:0]       state_q, state_d;
    logic [NUM_COINS-1:0][7:0]       frame_cnt_q, frame_cnt_d;
    logic [NUM_COINS-1:0]            active_q, active_d;
    logic [15:0]                     score_q, score_d;
    logic [7:0]                      combo_q, combo_d;
    logic                            hit_q, hit_d;
    logic                            miss_q, miss_d;
    logic                            whiff_q, whiff_d;
    logic                            drop_q, drop_d;

    logic [NUM_COINS-1:0]            idle_s;
    logic [NUM_COINS-1:0]            cand_s;
    logic [NUM_COINS-1:0]            spawn_sel_s;
    logic [NUM_COINS-1:0]            hit_sel_s;
    logic [NUM_COINS-1:0]            miss_vec_s;
    logic                            press_s;
    logic                            spawn_due_s;
    logic [16:0]                     score_sum_s;

    // Button synchronizer, rise detect and spawn interval timer
    always_comb begin
        btn_meta_d  = i_btn;
        btn_sync_d  = btn_meta_q;
        btn_prev_d  = btn_sync_q;
        // Presses while the lane is stopped are consumed without judgement
        press_s     = btn_sync_q & ~btn_prev_q & i_run;
        spawn_due_s = i_run & i_frame_tick & (spawn_cnt_q == SPAWN_LAST);
        if (!i_run) begin
            spawn_cnt_d = 8'd0;
        end else if (i_frame_tick) begin
            if (spawn_cnt_q == SPAWN_LAST) begin
                spawn_cnt_d = 8'd0;
            end else begin
                spawn_cnt_d = spawn_cnt_q + 8'd1;
            end
        end else begin
            spawn_cnt_d = spawn_cnt_q;
        end
    end

    // Slot status decode and arbitration for spawn and hit
    always_comb begin
        idle_s = '0;
        cand_s = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            idle_s[k] = (state_q[k] == ST_IDLE);
            cand_s[k] = (state_q[k] == ST_ARMED) & i_in_position[k];
        end
        if (spawn_due_s) begin
            spawn_sel_s = lowest_one(idle_s);
        end else begin
            spawn_sel_s = '0;
        end
        if (press_s) begin
            hit_sel_s = lowest_one(cand_s);
        end else begin
            hit_sel_s = '0;
        end
    end

    // Per-slot FSM; every state entry clears the slot's frame counter
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        miss_vec_s  = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            case (state_q[k])
                ST_IDLE: begin
                    if (spawn_sel_s[k]) begin
                        state_d[k]     = ST_FLY;
                        frame_cnt_d[k] = 8'd0;
                    end else begin
                        state_d[k]     = ST_IDLE;
                    end
                end
                ST_FLY: begin
                    if (!i_run) begin
                        state_d[k]     = ST_REL;
                        frame_cnt_d[k] = 8'd0;
                    end else if (i_in_position[k]) begin
                        state_d[k]     = ST_ARMED;
                        frame_cnt_d[k] = 8'd0;
                    end else if (i_frame_tick) begin
                        if (frame_cnt_q[k] == MAX_LAST) begin
                            state_d[k]     = ST_REL;
                            frame_cnt_d[k] = 8'd0;
                            miss_vec_s[k]  = 1'b1;
                        end else begin
                            frame_cnt_d[k] = frame_cnt_q[k] + 8'd1;
                        end
                    end else begin
                        state_d[k] = ST_FLY;
                    end
                end
                ST_ARMED: begin
                    if (!i_run || hit_sel_s[k]) begin
                        state_d[k]     = ST_REL;
                        frame_cnt_d[k] = 8'd0;
                    end else if (!i_in_position[k]) begin
                        state_d[k]     = ST_REL;
                        frame_cnt_d[k] = 8'd0;
                        miss_vec_s[k]  = 1'b1;
                    end else begin
                        state_d[k] = ST_ARMED;
                    end
                end
                ST_REL: begin
                    // Release runs to completion even while the lane is stopped
                    if (i_frame_tick) begin
                        if (frame_cnt_q[k] == REARM_LAST) begin
                            state_d[k]     = ST_IDLE;
                            frame_cnt_d[k] = 8'd0;
                        end else begin
                            frame_cnt_d[k] = frame_cnt_q[k] + 8'd1;
                        end
                    end else begin
                        state_d[k] = ST_REL;
                    end
                end
                default: begin
                    state_d[k]     = ST_IDLE;
                    frame_cnt_d[k] = 8'd0;
                end
            endcase
        end
    end

    // Output next-values: active lines, judgement pulses, score and combo
    always_comb begin
        active_d = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            active_d[k] = (state_d[k] == ST_FLY) || (state_d[k] == ST_ARMED);
        end
        hit_d   = |hit_sel_s;
        miss_d  = |miss_vec_s;
        whiff_d = press_s & ~(|cand_s);
        drop_d  = spawn_due_s & ~(|idle_s);

        score_sum_s = {1'b0, score_q} + HIT_INC;
        if (!hit_d) begin
            score_d = score_q;
        end else if (score_sum_s[16]) begin
            score_d = 16'hFFFF;
        end else begin
            score_d = score_sum_s[15:0];
        end

        // A miss in the same cycle as a hit still breaks the combo
        if (miss_d || whiff_d) begin
            combo_d = 8'd0;
        end else if (hit_d) begin
            if (combo_q == 8'hFF) begin
                combo_d = 8'hFF;
            end else begin
                combo_d = combo_q + 8'd1;
            end
        end else begin
            combo_d = combo_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            btn_prev_q  <= 1'b0;
            spawn_cnt_q <= 8'd0;
            state_q     <= '0;
            frame_cnt_q <= '0;
            active_q    <= '0;
            score_q     <= 16'd0;
            combo_q     <= 8'd0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            whiff_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            btn_prev_q  <= btn_prev_d;
            spawn_cnt_q <= spawn_cnt_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            active_q    <= active_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            whiff_q     <= whiff_d;
            drop_q      <= drop_d;
        end
    end

    assign o_active     = active_q;
    assign o_score      = score_q;
    assign o_combo      = combo_q;
    assign o_hit        = hit_q;
    assign o_miss       = miss_q;
    assign o_whiff      = whiff_q;
    assign o_spawn_drop = drop_q;

endmodule

// File: tb/tb_coin_lane_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coin_lane_ctrl
//   Two instances share one stimulus: u_dut with default parameters and
//   u_dut_sat with a large hit value so the score saturation is reachable in
//   a few hits. A behavioural lane model predicts every registered output
//   each cycle; directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_coin_lane_ctrl;

    localparam int NC      = 4;
    localparam int SI      = 12;
    localparam int MAXF    = 48;
    localparam int REARM   = 2;
    localparam int PTS     = 10;
    localparam int PTS_SAT = 13106;   // five hits land exactly on 16'hFFFA

    logic          clk = 1'b0;
    logic          rst_n, tick, run, btn;
    logic [NC-1:0] inpos;

    logic [NC-1:0] active, active_b;
    logic [15:0]   score, score_b;
    logic [7:0]    combo, combo_b;
    logic          hit, miss, whiff, drop;
    logic          hit_b, miss_b, whiff_b, drop_b;

    int n_tests = 0;
    int n_fail  = 0;

    coin_lane_ctrl #(.NUM_COINS(NC), .SPAWN_INTERVAL(SI), .MAX_FRAMES(MAXF),
                     .REARM_FRAMES(REARM), .HIT_POINTS(PTS)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_run(run), .i_btn(btn),
        .i_in_position(inpos), .o_active(active), .o_score(score), .o_combo(combo),
        .o_hit(hit), .o_miss(miss), .o_whiff(whiff), .o_spawn_drop(drop));

    coin_lane_ctrl #(.NUM_COINS(NC), .SPAWN_INTERVAL(SI), .MAX_FRAMES(MAXF),
                     .REARM_FRAMES(REARM), .HIT_POINTS(PTS_SAT)) u_dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_run(run), .i_btn(btn),
        .i_in_position(inpos), .o_active(active_b), .o_score(score_b), .o_combo(combo_b),
        .o_hit(hit_b), .o_miss(miss_b), .o_whiff(whiff_b), .o_spawn_drop(drop_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural lane model ----------------
    bit            m_valid;
    int            m_timer, m_score, m_score_b, m_combo;
    bit            m_out  [NC];   // coin is falling (active)
    bit            m_seen [NC];   // coin has reached the hit window
    int            m_age  [NC];   // frame ticks spent falling before the window
    int            m_cool [NC];   // frame ticks left until the slot can respawn
    bit            m_b1, m_b2, m_b3;   // i_btn as sampled 1, 2, 3 edges ago
    logic [NC-1:0] e_active;
    logic          e_hit, e_miss, e_whiff, e_drop;

    task automatic let_go(input int k);
        m_out[k]  = 1'b0;
        m_seen[k] = 1'b0;
        m_cool[k] = REARM;
    endtask

    always @(posedge clk) begin : model
        int hit_idx, spawn_idx;
        bit press, due;
        m_valid = 1'b1;
        if (!rst_n) begin
            m_timer = 0; m_score = 0; m_score_b = 0; m_combo = 0;
            m_b1 = 1'b0; m_b2 = 1'b0; m_b3 = 1'b0;
            for (int k = 0; k < NC; k++) begin
                m_out[k] = 1'b0; m_seen[k] = 1'b0; m_age[k] = 0; m_cool[k] = 0;
            end
            e_hit = 1'b0; e_miss = 1'b0; e_whiff = 1'b0; e_drop = 1'b0;
        end else begin
            press = m_b2 && !m_b3 && run;
            m_b3 = m_b2; m_b2 = m_b1; m_b1 = btn;
            due = run && tick && (m_timer == SI - 1);
            if (!run) m_timer = 0;
            else if (tick) m_timer = (m_timer == SI - 1) ? 0 : m_timer + 1;
            spawn_idx = -1;
            hit_idx   = -1;
            for (int k = 0; k < NC; k++) begin
                if (spawn_idx < 0 && !m_out[k] && m_cool[k] == 0) spawn_idx = k;
                if (press && hit_idx < 0 && m_out[k] && m_seen[k] && inpos[k]) hit_idx = k;
            end
            e_hit   = (hit_idx >= 0);
            e_whiff = press && (hit_idx < 0);
            e_drop  = due && (spawn_idx < 0);
            e_miss  = 1'b0;
            for (int k = 0; k < NC; k++) begin
                if (m_out[k]) begin
                    if (!run) let_go(k);
                    else if (m_seen[k]) begin
                        if (k == hit_idx) let_go(k);
                        else if (!inpos[k]) begin let_go(k); e_miss = 1'b1; end
                    end else if (inpos[k]) m_seen[k] = 1'b1;
                    else if (tick) begin
                        m_age[k]++;
                        if (m_age[k] == MAXF) begin let_go(k); e_miss = 1'b1; end
                    end
                end else if (m_cool[k] > 0) begin
                    if (tick) m_cool[k]--;
                end else if (due && k == spawn_idx) begin
                    m_out[k] = 1'b1; m_seen[k] = 1'b0; m_age[k] = 0;
                end
            end
            if (e_hit) begin
                m_score   = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
                m_score_b = (m_score_b + PTS_SAT > 65535) ? 65535 : m_score_b + PTS_SAT;
                m_combo   = (m_combo == 255) ? 255 : m_combo + 1;
            end
            if (e_miss || e_whiff) m_combo = 0;
        end
        for (int k = 0; k < NC; k++) e_active[k] = m_out[k];
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("active",     32'(active),  32'(e_active));
            chk("score",      32'(score),   32'(m_score));
            chk("combo",      32'(combo),   32'(m_combo));
            chk("pulses",     32'({hit, miss, whiff, drop}),
                              32'({e_hit, e_miss, e_whiff, e_drop}));
            chk("sat_score",  32'(score_b), 32'(m_score_b));
            chk("sat_others", 32'({active_b, combo_b, hit_b, miss_b, whiff_b, drop_b}),
                              32'({e_active, m_combo[7:0], e_hit, e_miss, e_whiff, e_drop}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one frame tick lasting one cycle; returns on the negedge after the sampling edge
    task automatic frame();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nwhiff, nhit, first_drop, first_miss, rate;
        rst_n = 1'b0; tick = 1'b0; run = 1'b0; btn = 1'b0; inpos = '0;
        cyc(3);
        chk("reset_active", 32'(active), 32'h0);
        chk("reset_score",  32'(score),  32'h0);
        chk("reset_combo",  32'(combo),  32'h0);
        rst_n = 1'b1; run = 1'b1;

        // 1: spawns on ticks 12 and 24
        for (int t = 1; t <= 24; t++) begin
            cyc(99);
            if (t == 12) chk("t1_before_tick12", 32'(active), 32'h0);
            frame();
            if (t == 12) chk("t1_after_tick12", 32'(active), 32'h1);
            if (t == 24) chk("t1_after_tick24", 32'(active), 32'h3);
        end

        // 2: hit on armed slot 0, judged three cycles after the press
        inpos = 4'b0001;
        cyc(1);
        btn = 1'b1;
        cyc(2);
        chk("t2_no_early_hit", 32'(hit), 32'h0);
        cyc(1);
        chk("t2_hit",    32'(hit),    32'h1);
        chk("t2_score",  32'(score),  32'd10);
        chk("t2_combo",  32'(combo),  32'd1);
        chk("t2_active", 32'(active), 32'h2);
        cyc(1);
        chk("t2_hit_width", 32'(hit), 32'h0);
        btn = 1'b0; inpos = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            cyc(9);
            frame();
            chk("t2_rearm_low", 32'(active[0]), 32'h0);
        end

        // 3: slot 1 enters then leaves the window unhit
        inpos = 4'b0010;
        cyc(1);
        inpos = 4'b0000;
        cyc(1);
        chk("t3_miss",  32'(miss),  32'h1);
        chk("t3_combo", 32'(combo), 32'h0);
        chk("t3_score", 32'(score), 32'd10);
        cyc(1);
        chk("t3_miss_width", 32'(miss), 32'h0);

        // 4: press with nothing in the window, held for 50 cycles
        nwhiff = 0; nhit = 0;
        btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (whiff) nwhiff++;
            if (hit) nhit++;
        end
        btn = 1'b0;
        cyc(4);
        chk("t4_whiff_count", 32'(nwhiff), 32'd1);
        chk("t4_hit_count",   32'(nhit),   32'd0);
        chk("t4_combo",       32'(combo),  32'd0);

        // 5: every slot kept falling; first drop and first timeout miss both on tick 60
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
        first_drop = -1; first_miss = -1;
        for (int t = 1; t <= 64; t++) begin
            frame();
            if (drop && first_drop < 0) first_drop = t;
            if (miss && first_miss < 0) first_miss = t;
            if (t == 48) chk("t5_all_flying", 32'(active), 32'hF);
            cyc(2);
        end
        chk("t5_first_drop", 32'(first_drop), 32'd60);
        chk("t5_first_miss", 32'(first_miss), 32'd60);

        // 6: repeated hits to saturation, then reset mid-flight
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
        for (int h = 1; h <= 6; h++) begin
            inpos = 4'b0000;
            repeat (12) begin frame(); cyc(1); end
            inpos = 4'b0001;
            cyc(1);
            btn = 1'b1;
            cyc(3);
            chk("t6_hit", 32'(hit), 32'h1);
            btn = 1'b0;
            cyc(3);
            if (h == 5) begin
                chk("t6_sat_preload", 32'(score_b), 32'hFFFA);
                chk("t6_score_5",     32'(score),   32'd50);
            end
        end
        chk("t6_saturated", 32'(score_b), 32'hFFFF);
        chk("t6_score_6",   32'(score),   32'd60);
        chk("t6_combo_6",   32'(combo),   32'd6);
        inpos = 4'b0000;
        repeat (12) begin frame(); cyc(1); end
        chk("t6_in_flight", 32'(active), 32'h1);
        rst_n = 1'b0;
        cyc(1);
        chk("t6_rst_outputs", 32'({active, score, combo, hit, miss, whiff, drop}), 32'h0);
        chk("t6_rst_sat",     32'(score_b), 32'h0);
        rst_n = 1'b1;

        // randomized play, checked cycle by cycle against the model
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: rate = 2;
                1: rate = 8;
                2: rate = 40;
                default: rate = 400;
            endcase
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                tick = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 99) == 0) run = ~run;
                if ($urandom_range(0, 5) == 0) btn = ~btn;
                for (int k = 0; k < NC; k++)
                    if ($urandom_range(0, rate - 1) == 0) inpos[k] = ~inpos[k];
                rst_n = ($urandom_range(0, 999) != 0);
            end
            run = 1'b1;
        end
        rst_n = 1'b1; tick = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
